// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port unified memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_AUX = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/mem_port_arbiter_arb2_grant.sv
// Combinational two-way grant selector: round-robin or CPU-first on a tie.
module arb2_grant
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_reqs,     // [0] = CPU, [1] = AUX
    input  logic       i_last,     // last-served owner code
    input  logic       i_mode,     // 1 = CPU fixed priority
    output logic       o_winner
);

    always_comb begin
        o_winner = OWN_CPU;
        if (i_reqs[1] && !i_reqs[0]) begin
            o_winner = OWN_AUX;
        end else if (i_reqs[1] && i_reqs[0] && !i_mode) begin
            o_winner = ~i_last;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and AUX accesses onto one synchronous memory port with
// a req/ack handshake per requester and registered outputs throughout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LAT       = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCpuReq,
    input  logic              iCpuWe,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuWData,
    output logic              oCpuAck,
    output logic [DATA_W-1:0] oCpuRData,
    input  logic              iAuxReq,
    input  logic              iAuxWe,
    input  logic [ADDR_W-1:0] iAuxAddr,
    input  logic [DATA_W-1:0] iAuxWData,
    output logic              oAuxAck,
    output logic [DATA_W-1:0] oAuxRData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic              oMemWe,
    output logic              oMemRe,
    input  logic [DATA_W-1:0] iMemRData,
    output logic              oBusy,
    output logic              oOwner
);

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("mem_port_arbiter: LAT must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    arb_state_t        r_state;
    logic [1:0]        r_cnt;
    logic              r_we;
    logic              r_owner;
    logic              r_last;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_cpu_ack;
    logic              r_aux_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_aux_rdata;

    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    arb2_grant u_grant (
        .i_reqs   ({iAuxReq, iCpuReq}),
        .i_last   (r_last),
        .i_mode   (PRIO_MODE == PRIO_FIXED),
        .o_winner (w_winner)
    );

    assign w_sel_we    = (w_winner == OWN_AUX) ? iAuxWe    : iCpuWe;
    assign w_sel_addr  = (w_winner == OWN_AUX) ? iAuxAddr  : iCpuAddr;
    assign w_sel_wdata = (w_winner == OWN_AUX) ? iAuxWData : iCpuWData;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_owner     <= OWN_CPU;
            r_last      <= OWN_AUX;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_aux_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_aux_rdata <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses unless set below.
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_aux_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_aux_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (iCpuReq || iAuxReq) begin
                        r_owner     <= w_winner;
                        r_we        <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we;
                        r_mem_re    <= ~w_sel_we;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        r_cpu_ack <= (r_owner == OWN_CPU);
                        r_aux_ack <= (r_owner == OWN_AUX);
                        r_state   <= ST_ACK;
                    end else begin
                        r_cnt   <= CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        // Final wait cycle: memory data is valid now.
                        if (r_owner == OWN_CPU) begin
                            r_cpu_ack   <= 1'b1;
                            r_cpu_rdata <= iMemRData;
                        end else begin
                            r_aux_ack   <= 1'b1;
                            r_aux_rdata <= iMemRData;
                        end
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oCpuAck   = r_cpu_ack;
    assign oCpuRData = r_cpu_rdata;
    assign oAuxAck   = r_aux_ack;
    assign oAuxRData = r_aux_rdata;
    assign oMemAddr  = r_mem_addr;
    assign oMemWData = r_mem_wdata;
    assign oMemWe    = r_mem_we;
    assign oMemRe    = r_mem_re;
    assign oBusy     = r_busy;
    assign oOwner    = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A (LAT=1, round-robin), instance B (LAT=3, CPU priority).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_rst, a_cpu_req, a_cpu_we, a_aux_req, a_aux_we;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_aux_addr, a_aux_wdata;
    logic        a_cpu_ack, a_aux_ack, a_mem_we, a_mem_re, a_busy, a_owner;
    logic [31:0] a_cpu_rdata, a_aux_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B signals
    logic        b_rst, b_cpu_req, b_cpu_we, b_aux_req, b_aux_we;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_aux_addr, b_aux_wdata;
    logic        b_cpu_ack, b_aux_ack, b_mem_we, b_mem_re, b_busy, b_owner;
    logic [31:0] b_cpu_rdata, b_aux_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .LAT(1), .PRIO_MODE(0)) u_dut_a (
        .iCLK(clk), .iRST(a_rst),
        .iCpuReq(a_cpu_req), .iCpuWe(a_cpu_we), .iCpuAddr(a_cpu_addr), .iCpuWData(a_cpu_wdata),
        .oCpuAck(a_cpu_ack), .oCpuRData(a_cpu_rdata),
        .iAuxReq(a_aux_req), .iAuxWe(a_aux_we), .iAuxAddr(a_aux_addr), .iAuxWData(a_aux_wdata),
        .oAuxAck(a_aux_ack), .oAuxRData(a_aux_rdata),
        .oMemAddr(a_mem_addr), .oMemWData(a_mem_wdata), .oMemWe(a_mem_we), .oMemRe(a_mem_re),
        .iMemRData(a_mem_rdata), .oBusy(a_busy), .oOwner(a_owner)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .LAT(3), .PRIO_MODE(1)) u_dut_b (
        .iCLK(clk), .iRST(b_rst),
        .iCpuReq(b_cpu_req), .iCpuWe(b_cpu_we), .iCpuAddr(b_cpu_addr), .iCpuWData(b_cpu_wdata),
        .oCpuAck(b_cpu_ack), .oCpuRData(b_cpu_rdata),
        .iAuxReq(b_aux_req), .iAuxWe(b_aux_we), .iAuxAddr(b_aux_addr), .iAuxWData(b_aux_wdata),
        .oAuxAck(b_aux_ack), .oAuxRData(b_aux_rdata),
        .oMemAddr(b_mem_addr), .oMemWData(b_mem_wdata), .oMemWe(b_mem_we), .oMemRe(b_mem_re),
        .iMemRData(b_mem_rdata), .oBusy(b_busy), .oOwner(b_owner)
    );

    // Memory model A: 256 words, one-cycle synchronous read
    logic [31:0] mem_a [256];
    logic        preload_a;
    always @(posedge clk) begin
        if (preload_a) mem_a[8'h10] <= 32'hDEADBEEF;
        if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
        if (a_mem_re) a_mem_rdata <= mem_a[a_mem_addr[9:2]];
    end

    // Memory model B: read bus shows C0DE0000 + cycle number, so capture timing is visible
    int b_cyc = 0;
    always @(posedge clk) begin
        b_cyc       <= b_cyc + 1;
        b_mem_rdata <= 32'hC0DE0000 + 32'(b_cyc + 1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int nc, na, k, s;
        logic flag;

        a_rst = 1'b1; b_rst = 1'b1; preload_a = 1'b1;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_aux_req = 0; a_aux_we = 0; a_aux_addr = 0; a_aux_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_aux_req = 0; b_aux_we = 0; b_aux_addr = 0; b_aux_wdata = 0;
        repeat (2) tick();
        preload_a = 1'b0;

        check("a_rst_ctrl", 32'({a_cpu_ack, a_aux_ack, a_mem_we, a_mem_re, a_busy, a_owner}), 32'h0);
        check("a_rst_addr", a_mem_addr, 32'h0);
        check("a_rst_wdata", a_mem_wdata, 32'h0);
        check("a_rst_rdata", a_cpu_rdata | a_aux_rdata, 32'h0);
        a_rst = 1'b0; b_rst = 1'b0;
        tick();

        // CPU read of 0x40, LAT=1
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h40;
        tick();
        check("rd_c1_re", 32'(a_mem_re), 32'd1);
        check("rd_c1_we", 32'(a_mem_we), 32'd0);
        check("rd_c1_addr", a_mem_addr, 32'h40);
        check("rd_c1_busy", 32'(a_busy), 32'd1);
        tick();
        check("rd_c2_noack", 32'(a_cpu_ack), 32'd0);
        tick();
        check("rd_c3_ack", 32'(a_cpu_ack), 32'd1);
        check("rd_c3_data", a_cpu_rdata, 32'hDEADBEEF);
        check("rd_c3_owner", 32'(a_owner), 32'd0);
        a_cpu_req = 0;
        tick();
        check("rd_idle_busy", 32'(a_busy), 32'd0);

        // AUX write of 0x12345678 to 0x100
        a_aux_req = 1; a_aux_we = 1; a_aux_addr = 32'h100; a_aux_wdata = 32'h12345678;
        tick();
        check("wr_c1_we", 32'(a_mem_we), 32'd1);
        check("wr_c1_re", 32'(a_mem_re), 32'd0);
        check("wr_c1_addr", a_mem_addr, 32'h100);
        check("wr_c1_wdata", a_mem_wdata, 32'h12345678);
        check("wr_c1_owner", 32'(a_owner), 32'd1);
        tick();
        check("wr_c2_ack", 32'(a_aux_ack), 32'd1);
        check("wr_c2_rdata", a_aux_rdata, 32'h0);
        check("wr_c2_cpuack", 32'(a_cpu_ack), 32'd0);
        a_aux_req = 0; a_aux_we = 0;
        tick();
        check("wr_mem", mem_a[8'h40], 32'h12345678);

        // Round-robin: both ports hold read requests for 4 accesses each
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h10;
        a_aux_req = 1; a_aux_we = 0; a_aux_addr = 32'h20;
        nc = 0; na = 0; k = 0; flag = 1'b0;
        for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
            tick();
            if ((a_mem_we && a_mem_re) || (a_cpu_ack && a_aux_ack)) flag = 1'b1;
            if (a_cpu_ack || a_aux_ack) begin
                check($sformatf("rr_grant%0d", k), 32'(a_aux_ack), 32'(k % 2));
                k++;
                if (a_cpu_ack) begin nc++; if (nc == 4) a_cpu_req = 0; end
                if (a_aux_ack) begin na++; if (na == 4) a_aux_req = 0; end
            end
        end
        a_cpu_req = 0; a_aux_req = 0;
        check("rr_total", 32'(k), 32'd8);
        check("rr_overlap", 32'(flag), 32'd0);
        tick();

        // Fixed priority on B: CPU holds req for 5 reads while AUX waits
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h8;
        b_aux_req = 1; b_aux_we = 0; b_aux_addr = 32'hC;
        nc = 0; na = 0;
        for (int cyc = 0; cyc < 300 && nc < 5; cyc++) begin
            tick();
            if (b_aux_ack) na++;
            if (b_cpu_ack) begin nc++; if (nc == 5) b_cpu_req = 0; end
        end
        check("fx_cpu_acks", 32'(nc), 32'd5);
        check("fx_aux_acks", 32'(na), 32'd0);
        tick();
        tick();
        check("fx_aux_owner", 32'(b_owner), 32'd1);
        check("fx_aux_re", 32'(b_mem_re), 32'd1);
        flag = 1'b0;
        for (int cyc = 0; cyc < 20 && !flag; cyc++) begin
            tick();
            if (b_aux_ack) flag = 1'b1;
        end
        check("fx_aux_ack", 32'(flag), 32'd1);
        b_aux_req = 0;
        tick();

        // LAT=3 CPU read: ack in cycle 5 with data presented in cycle 4
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h80;
        tick();
        check("l3_c1_re", 32'(b_mem_re), 32'd1);
        s = b_cyc;
        flag = 1'b0;
        repeat (3) begin tick(); if (b_cpu_ack) flag = 1'b1; end
        check("l3_early_ack", 32'(flag), 32'd0);
        tick();
        check("l3_c5_ack", 32'(b_cpu_ack), 32'd1);
        check("l3_c5_data", b_cpu_rdata, 32'hC0DE0000 + 32'(s + 3));
        b_cpu_req = 0;
        tick();

        // Reset pulsed during the wait phase of a read
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h84;
        tick();
        tick();
        check("rs_in_wait", 32'({b_busy, b_mem_re}), 32'b10);
        b_rst = 1'b1;
        #1;
        check("rs_ctrl", 32'({b_cpu_ack, b_aux_ack, b_mem_we, b_mem_re, b_busy, b_owner}), 32'h0);
        check("rs_addr", b_mem_addr, 32'h0);
        check("rs_rdata", b_cpu_rdata | b_aux_rdata, 32'h0);
        b_cpu_req = 0;
        tick();
        b_rst = 1'b0;
        flag = 1'b0;
        repeat (8) begin
            tick();
            if (b_cpu_ack || b_aux_ack || b_mem_we || b_mem_re || b_busy) flag = 1'b1;
        end
        check("rs_quiet", 32'(flag), 32'd0);
        b_cpu_req = 1; b_cpu_addr = 32'h88;
        tick();
        check("rs2_c1_re", 32'(b_mem_re), 32'd1);
        check("rs2_c1_addr", b_mem_addr, 32'h88);
        s = b_cyc;
        flag = 1'b0;
        repeat (3) begin tick(); if (b_cpu_ack) flag = 1'b1; end
        check("rs2_early_ack", 32'(flag), 32'd0);
        tick();
        check("rs2_c5_ack", 32'(b_cpu_ack), 32'd1);
        check("rs2_c5_data", b_cpu_rdata, 32'hC0DE0000 + 32'(s + 3));
        b_cpu_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
